// File: rtl/pipe_cpu_pkg.sv
// Shared encodings for pipe_cpu_param: opcodes, instruction layout, NOP words and EX control typedef.
// Field positions are fixed by instr_t: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm.
package pipe_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] imm;
    } instr_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] imm;
    } ctl_t;

    localparam instr_t NOP_INSTR = instr_t'(16'h0000);
    localparam ctl_t   NOP_CTL   = ctl_t'(12'h000);

    // Undefined opcodes collapse to NOP so later stages only ever see legal ops.
    function automatic logic [3:0] op_norm(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST,
            OP_LDI, OP_BEQZ, OP_HALT: return op;
            default:                  return OP_NOP;
        endcase
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        return is_alu(op) || (op == OP_LD) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/pipe_cpu_alu.sv
// Combinational ADD/SUB/AND/OR on DATA_W-bit operands, results wrap mod 2^DATA_W.
module pipe_cpu_alu
    import pipe_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/pipe_cpu_param.sv
// Parametrised 4-stage (IF/ID/EX/WB) in-order CPU with BEQZ flush, HALT and RAW hazard handling.
// PIPE_CPU_FORWARD_EN: forward EX result into ID; otherwise ID stalls behind a dependent EX writer.
module pipe_cpu_param
    import pipe_cpu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREGS      = 16,
    parameter  int IMEM_DEPTH = 64,
    parameter  int DMEM_DEPTH = 256,
    localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              halted,
    output logic [PC_W-1:0]   pc_out,
    output logic              retire,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    localparam int DA_W = $clog2(DMEM_DEPTH);

    logic [15:0]       imem     [IMEM_DEPTH];
    logic [DATA_W-1:0] data_mem [DMEM_DEPTH];
    logic [DATA_W-1:0] regfile  [NREGS];

    logic [PC_W-1:0]   r_pc;
    instr_t            r_ifid_instr;
    logic [PC_W-1:0]   r_ifid_pc;
    ctl_t              r_idex_ctl;
    logic [PC_W-1:0]   r_idex_pc;
    logic [DATA_W-1:0] r_idex_a;
    logic [DATA_W-1:0] r_idex_b;
    logic              r_exwb_vld;
    logic              r_exwb_we;
    logic [3:0]        r_exwb_rd;
    logic [DATA_W-1:0] r_exwb_data;
    logic              r_halted;

    logic [3:0]        w_id_op;
    logic [3:0]        w_id_rb;
    logic [DATA_W-1:0] w_id_a;
    logic [DATA_W-1:0] w_id_b;
    logic              w_stall;
    logic [3:0]        w_ex_op;
    logic [DATA_W-1:0] w_alu_y;
    logic [DA_W-1:0]   w_dmem_addr;
    logic [DATA_W-1:0] w_ex_result;
    logic              w_ex_we;
    logic              w_ex_retire;
    logic              w_ex_halt;
    logic              w_br_taken;
    logic signed [3:0] w_simm;
    logic [PC_W-1:0]   w_br_target;
    logic [PC_W-1:0]   w_pc_inc;

    // ---------------- ID: decode and operand read ----------------
    assign w_id_op = op_norm(r_ifid_instr.op);
    // Second read port carries rd for ST (store data) and BEQZ (tested register).
    assign w_id_rb = ((w_id_op == OP_ST) || (w_id_op == OP_BEQZ)) ? r_ifid_instr.rd
                                                                    : r_ifid_instr.imm;

    always_comb begin
        w_id_a = regfile[r_ifid_instr.rs1];
        w_id_b = regfile[w_id_rb];
        if (r_exwb_we && (r_exwb_rd == r_ifid_instr.rs1)) w_id_a = r_exwb_data;
        if (r_exwb_we && (r_exwb_rd == w_id_rb))          w_id_b = r_exwb_data;
`ifdef PIPE_CPU_FORWARD_EN
        if (w_ex_we && (r_idex_ctl.rd == r_ifid_instr.rs1)) w_id_a = w_ex_result;
        if (w_ex_we && (r_idex_ctl.rd == w_id_rb))          w_id_b = w_ex_result;
`endif
    end

`ifdef PIPE_CPU_FORWARD_EN
    assign w_stall = 1'b0;
`else
    logic w_id_use_a;
    logic w_id_use_b;
    assign w_id_use_a = is_alu(w_id_op) || (w_id_op == OP_LD) || (w_id_op == OP_ST);
    assign w_id_use_b = is_alu(w_id_op) || (w_id_op == OP_ST) || (w_id_op == OP_BEQZ);
    assign w_stall    = w_ex_we &&
                        ((w_id_use_a && (r_idex_ctl.rd == r_ifid_instr.rs1)) ||
                         (w_id_use_b && (r_idex_ctl.rd == w_id_rb)));
`endif

    // ---------------- EX: ALU, memory, branch ----------------
    assign w_ex_op = r_idex_ctl.op;

    pipe_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op (w_ex_op),
        .i_a  (r_idex_a),
        .i_b  (r_idex_b),
        .o_y  (w_alu_y)
    );

    assign w_dmem_addr = DA_W'(r_idex_a) + DA_W'(r_idex_ctl.imm);

    always_comb begin
        w_ex_result = '0;
        case (w_ex_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: w_ex_result = w_alu_y;
            OP_LD:                         w_ex_result = data_mem[w_dmem_addr];
            OP_LDI:                        w_ex_result = DATA_W'(r_idex_ctl.imm);
            default:                       w_ex_result = '0;
        endcase
    end

    assign w_ex_we     = writes_reg(w_ex_op);
    assign w_ex_halt   = (w_ex_op == OP_HALT);
    assign w_ex_retire = (w_ex_op != OP_NOP) && !w_ex_halt;
    assign w_br_taken  = (w_ex_op == OP_BEQZ) && (r_idex_b == '0);
    assign w_simm      = r_idex_ctl.imm;
    assign w_br_target = r_idex_pc + PC_W'(1) + PC_W'(w_simm);
    assign w_pc_inc    = (r_pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : r_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (w_ex_op == OP_ST) data_mem[w_dmem_addr] <= r_idex_b;
    end

    // ---------------- pipeline registers and WB ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_idex_ctl   <= NOP_CTL;
            r_idex_pc    <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_exwb_vld   <= 1'b0;
            r_exwb_we    <= 1'b0;
            r_exwb_rd    <= '0;
            r_exwb_data  <= '0;
            r_halted     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
        end else begin
            if (r_exwb_we) regfile[r_exwb_rd] <= r_exwb_data;
            r_exwb_vld  <= w_ex_retire;
            r_exwb_we   <= w_ex_we;
            r_exwb_rd   <= r_idex_ctl.rd;
            r_exwb_data <= w_ex_result;
            // Flush (branch/HALT) outranks a concurrent stall.
            if (w_ex_halt || w_br_taken || r_halted) begin
                r_ifid_instr <= NOP_INSTR;
                r_idex_ctl   <= NOP_CTL;
                if (w_ex_halt)  r_halted <= 1'b1;
                if (w_br_taken) r_pc     <= w_br_target;
            end else if (w_stall) begin
                r_idex_ctl <= NOP_CTL;
            end else begin
                r_pc         <= w_pc_inc;
                r_ifid_instr <= instr_t'(imem[r_pc]);
                r_ifid_pc    <= r_pc;
                r_idex_ctl   <= '{op: w_id_op, rd: r_ifid_instr.rd, imm: r_ifid_instr.imm};
                r_idex_pc    <= r_ifid_pc;
                r_idex_a     <= w_id_a;
                r_idex_b     <= w_id_b;
            end
        end
    end

    assign halted  = r_halted;
    assign pc_out  = r_pc;
    assign retire  = r_exwb_vld;
    assign wb_en   = r_exwb_we;
    assign wb_addr = r_exwb_rd;
    assign wb_data = r_exwb_data;

endmodule

// File: tb/tb_pipe_cpu_param.sv
// Directed bench for pipe_cpu_param: default config, a 4-bit datapath instance and a 4-deep imem instance.
module tb_pipe_cpu_param;

`ifdef PIPE_CPU_FORWARD_EN
    localparam int HALT_EDGE = 7;
`else
    localparam int HALT_EDGE = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       halted, retire, wb_en;
    logic [5:0] pc_out;
    logic [3:0] wb_addr;
    logic [7:0] wb_data;

    logic       n_halted, n_retire, n_wb_en;
    logic [5:0] n_pc_out;
    logic [3:0] n_wb_addr;
    logic [3:0] n_wb_data;

    logic       w_halted, w_retire, w_wb_en;
    logic [1:0] w_pc_out;
    logic [3:0] w_wb_addr;
    logic [7:0] w_wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_cpu_param dut (
        .clk(clk), .rst(rst), .halted(halted), .pc_out(pc_out), .retire(retire),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    pipe_cpu_param #(.DATA_W(4)) dut4 (
        .clk(clk), .rst(rst), .halted(n_halted), .pc_out(n_pc_out), .retire(n_retire),
        .wb_en(n_wb_en), .wb_addr(n_wb_addr), .wb_data(n_wb_data)
    );

    pipe_cpu_param #(.IMEM_DEPTH(4)) dutw (
        .clk(clk), .rst(rst), .halted(w_halted), .pc_out(w_pc_out), .retire(w_retire),
        .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data)
    );

    task automatic clear_mems();
        for (int i = 0; i < 64; i++) begin
            dut.imem[i]  = 16'h0000;
            dut4.imem[i] = 16'h0000;
        end
        for (int i = 0; i < 4; i++) dutw.imem[i] = 16'h0000;
        for (int i = 0; i < 256; i++) dut.data_mem[i] = 8'h00;
    endtask

    // Leaves rst released 1 time unit after an edge: the next rising edge is edge 1.
    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_to_halt(input int max_cyc, output int edges, output int rets, output bit ok);
        edges = 0; rets = 0; ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            edges++;
            if (retire) rets++;
            if (halted) begin ok = 1'b1; break; end
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (retire) rets++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_tests++; if (pc_out !== 6'd0) begin n_fail++; $display("FAIL reset_pc: got %0d, expected 0", pc_out); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b, expected 0", halted); end
        n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %0b, expected 0", retire); end
        n_tests++; if (wb_en !== 1'b0)  begin n_fail++; $display("FAIL reset_wb_en: got %0b, expected 0", wb_en); end
        n_tests++; if (dut.regfile[5] !== 8'h00) begin n_fail++; $display("FAIL reset_regfile: got %0h, expected 0", dut.regfile[5]); end
    endtask

    task automatic test_load_store();
        int edges, rets; bit ok;
        clear_mems();
        dut.data_mem[0] = 8'h05;
        dut.data_mem[1] = 8'h03;
        dut.imem[0] = 16'h5030;  // LD  r0, r3+0
        dut.imem[1] = 16'h5131;  // LD  r1, r3+1
        dut.imem[2] = 16'h1201;  // ADD r2, r0, r1
        dut.imem[3] = 16'h6232;  // ST  r2, r3+2
        dut.imem[4] = 16'hF000;  // HALT
        apply_reset();
        run_to_halt(40, edges, rets, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ls_timeout: halted=%0b after 40 cycles, expected 1", halted); end
        n_tests++; if (edges !== HALT_EDGE) begin n_fail++; $display("FAIL ls_halt_edge: got %0d, expected %0d", edges, HALT_EDGE); end
        n_tests++; if (rets !== 4) begin n_fail++; $display("FAIL ls_retires: got %0d, expected 4", rets); end
        n_tests++; if (dut.regfile[2] !== 8'h08) begin n_fail++; $display("FAIL ls_r2: got %0h, expected 08", dut.regfile[2]); end
        n_tests++; if (dut.regfile[0] !== 8'h05) begin n_fail++; $display("FAIL ls_r0: got %0h, expected 05", dut.regfile[0]); end
        n_tests++; if (dut.data_mem[2] !== 8'h08) begin n_fail++; $display("FAIL ls_dmem2: got %0h, expected 08", dut.data_mem[2]); end
        n_tests++; if (pc_out !== 6'd6) begin n_fail++; $display("FAIL ls_pc_frozen: got %0d, expected 6", pc_out); end
    endtask

    task automatic test_alu_width();
        bit ok;
        clear_mems();
        dut.imem[0] = 16'h710F; dut4.imem[0] = 16'h710F;  // LDI r1, F
        dut.imem[1] = 16'h7201; dut4.imem[1] = 16'h7201;  // LDI r2, 1
        dut.imem[2] = 16'h1312; dut4.imem[2] = 16'h1312;  // ADD r3, r1, r2
        dut.imem[3] = 16'hF000; dut4.imem[3] = 16'hF000;  // HALT
        apply_reset();
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (halted && n_halted) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL alu_timeout: halted=%0b/%0b, expected 1/1", halted, n_halted); end
        n_tests++; if (dut.regfile[3] !== 8'h10) begin n_fail++; $display("FAIL alu_r3_w8: got %0h, expected 10", dut.regfile[3]); end
        n_tests++; if (dut4.regfile[3] !== 4'h0) begin n_fail++; $display("FAIL alu_r3_w4: got %0h, expected 0", dut4.regfile[3]); end
        n_tests++; if (dut4.regfile[1] !== 4'hF) begin n_fail++; $display("FAIL alu_r1_w4: got %0h, expected f", dut4.regfile[1]); end
    endtask

    task automatic test_branch_taken();
        int edges, rets; bit ok;
        clear_mems();
        dut.imem[0] = 16'h7100;  // LDI r1, 0
        dut.imem[1] = 16'h8102;  // BEQZ r1, +2
        dut.imem[2] = 16'h7407;  // LDI r4, 7 (skipped)
        dut.imem[3] = 16'h7507;  // LDI r5, 7 (skipped)
        dut.imem[4] = 16'h7609;  // LDI r6, 9
        dut.imem[5] = 16'hF000;  // HALT
        apply_reset();
        run_to_halt(40, edges, rets, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL br_timeout: halted=%0b, expected 1", halted); end
        n_tests++; if (dut.regfile[4] !== 8'h00) begin n_fail++; $display("FAIL br_r4: got %0h, expected 00", dut.regfile[4]); end
        n_tests++; if (dut.regfile[5] !== 8'h00) begin n_fail++; $display("FAIL br_r5: got %0h, expected 00", dut.regfile[5]); end
        n_tests++; if (dut.regfile[6] !== 8'h09) begin n_fail++; $display("FAIL br_r6: got %0h, expected 09", dut.regfile[6]); end
        n_tests++; if (rets !== 3) begin n_fail++; $display("FAIL br_retires: got %0d, expected 3", rets); end
    endtask

    task automatic test_branch_not_taken();
        int edges, rets; bit ok;
        clear_mems();
        dut.imem[0] = 16'h7101;  // LDI r1, 1
        dut.imem[1] = 16'h8102;  // BEQZ r1, +2 (not taken)
        dut.imem[2] = 16'h7407;  // LDI r4, 7
        dut.imem[3] = 16'h7507;  // LDI r5, 7
        dut.imem[4] = 16'hF000;  // HALT
        apply_reset();
        run_to_halt(40, edges, rets, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bnt_timeout: halted=%0b, expected 1", halted); end
        n_tests++; if (dut.regfile[4] !== 8'h07) begin n_fail++; $display("FAIL bnt_r4: got %0h, expected 07", dut.regfile[4]); end
        n_tests++; if (dut.regfile[5] !== 8'h07) begin n_fail++; $display("FAIL bnt_r5: got %0h, expected 07", dut.regfile[5]); end
        n_tests++; if (rets !== 4) begin n_fail++; $display("FAIL bnt_retires: got %0d, expected 4", rets); end
    endtask

    // Entered with the default instance halted from the previous program.
    task automatic test_reset_mid();
        int rets;
        #1 rst = 1'b0;
        #1;
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL mid_halt_clear: got %0b, expected 0", halted); end
        clear_mems();
        dut.data_mem[5] = 8'h33;
        dut.imem[0] = 16'h7706;  // LDI r7, 6
        dut.imem[1] = 16'h7109;  // LDI r1, 9
        dut.imem[2] = 16'h0000;  // NOP
        dut.imem[3] = 16'h6135;  // ST r1, r3+5
        apply_reset();
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (dut.regfile[7] !== 8'h06) begin n_fail++; $display("FAIL mid_r7_before: got %0h, expected 06", dut.regfile[7]); end
        rst = 1'b0;
        #1;
        n_tests++; if (pc_out !== 6'd0) begin n_fail++; $display("FAIL mid_pc: got %0d, expected 0", pc_out); end
        n_tests++; if (dut.regfile[7] !== 8'h00) begin n_fail++; $display("FAIL mid_r7_clear: got %0h, expected 00", dut.regfile[7]); end
        n_tests++; if (dut.regfile[1] !== 8'h00) begin n_fail++; $display("FAIL mid_r1_clear: got %0h, expected 00", dut.regfile[1]); end
        n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL mid_wb_en: got %0b, expected 0", wb_en); end
        rets = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (retire) rets++;
        end
        n_tests++; if (rets !== 0) begin n_fail++; $display("FAIL mid_retire_in_reset: got %0d pulses, expected 0", rets); end
        n_tests++; if (dut.data_mem[5] !== 8'h33) begin n_fail++; $display("FAIL mid_dmem_untouched: got %0h, expected 33", dut.data_mem[5]); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL mid_retire_after_release: got %0b, expected 0", retire); end
    endtask

    task automatic test_pc_wrap();
        logic [1:0] exp_pc [4];
        exp_pc = '{2'd1, 2'd2, 2'd3, 2'd0};
        clear_mems();
        apply_reset();
        n_tests++; if (w_pc_out !== 2'd0) begin n_fail++; $display("FAIL wrap_pc_start: got %0d, expected 0", w_pc_out); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (w_pc_out !== exp_pc[i]) begin
                n_fail++; $display("FAIL wrap_pc_%0d: got %0d, expected %0d", i, w_pc_out, exp_pc[i]);
            end
        end
    endtask

    initial begin
        clear_mems();
        test_reset();
        test_load_store();
        test_alu_width();
        test_branch_taken();
        test_branch_not_taken();
        test_reset_mid();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
